mem_responder: RTL and testbench

Memory-side responder for the multicycle controller's memory port: the controller initiates word-aligned reads and writes, and this block answers them. It holds the unified instruction/data word RAM and a small memory-mapped I/O page with a buffered console transmit FIFO and a free-running cycle counter. It sits beside the register file and ALU in the core top level, wired directly to the controller's `mem_addr`/`mem_write_en`/`mem_write_data`/`mem_data` signals.

---
 rtl/mem_map_pkg.sv | 36 +++
 rtl/con_fifo.sv | 63 ++++++
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants for the memory responder.
// MMIO page base/offsets, CON_STAT field layout and the address decoder.
package mem_map_pkg;

    localparam logic [31:0] MMIO_BASE    = 32'hFFFF_0000;
    localparam logic [31:0] CON_DATA_OFF = 32'h0000_0000;
    localparam logic [31:0] CON_STAT_OFF = 32'h0000_0004;
    localparam logic [31:0] CYCLES_OFF   = 32'h0000_0008;

    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 8;
    localparam int STAT_OVF_BIT = 8;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_CON_DATA,
        SEL_CON_STAT,
        SEL_CYCLES,
        SEL_NONE
    } sel_e;

    // Decodes a word address against the MMIO page only.
    function automatic sel_e mmio_sel(input logic [29:0] word);
        logic [31:0] a;
        a = {word, 2'b00};
        if (a == MMIO_BASE + CON_DATA_OFF)
            return SEL_CON_DATA;
        else if (a == MMIO_BASE + CON_STAT_OFF)
            return SEL_CON_STAT;
        else if (a == MMIO_BASE + CYCLES_OFF)
            return SEL_CYCLES;
        else
            return SEL_NONE;
    endfunction

endpackage

// File: rtl/con_fifo.sv
// Byte FIFO buffering console output.
// A push into a full FIFO is taken only if a pop happens in the same cycle.
module con_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [7:0]              push_data,
    output logic                    full,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    valid,
    input  logic                    ready,
    output logic [7:0]              data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop;
    logic          acc;

    assign full     = (cnt == CW'(DEPTH));
    assign valid    = (cnt != '0);
    assign pop      = valid & ready;
    assign acc      = push & (~full | pop);
    assign count    = cnt;
    assign data     = valid ? store[rd_ptr] : 8'h00;

    // Pointer, occupancy and sticky overflow tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (acc)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({acc, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (push && !acc)
                overflow <= 1'b1;
        end
    end

    // Entry storage; output is masked when empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (acc && !reset)
            store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM, cycle counter and console MMIO.
// Define MEM_CONSOLE_EN to build the console FIFO and CON_* registers.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int CON_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_write_en,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_data,
    output logic        mem_fault,
    output logic        con_valid,
    input  logic        con_ready,
    output logic [7:0]  con_byte
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   ram [MEM_WORDS];
    logic [AW-1:0] idx;
    sel_e          sel;
    logic [31:0]   cycles;
    logic [31:0]   stat_word;
    logic [31:0]   rd_word;
    logic          wr_ram;

    assign idx    = mem_addr[AW+1:2];
    assign wr_ram = mem_write_en & (sel == SEL_RAM) & ~reset;

    // Address decode: RAM window at 0, otherwise the MMIO page.
    always_comb begin
        if (mem_addr[31:AW+2] == '0)
            sel = SEL_RAM;
        else
            sel = mmio_sel(mem_addr[31:2]);
    end

`ifdef MEM_CONSOLE_EN
    logic                     fifo_full;
    logic                     fifo_ovf;
    logic [$clog2(CON_DEPTH):0] fifo_count;
    logic [31:0]              cnt32;
    logic                     con_push;
    logic                     unused_ok;

    assign con_push  = mem_write_en & (sel == SEL_CON_DATA);
    assign cnt32     = 32'(fifo_count);
    assign unused_ok = ^{mem_addr[1:0], fifo_full};

    con_fifo #(
        .DEPTH     (CON_DEPTH)
    ) u_con_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (con_push),
        .push_data (mem_write_data[7:0]),
        .full      (fifo_full),
        .overflow  (fifo_ovf),
        .count     (fifo_count),
        .valid     (con_valid),
        .ready     (con_ready),
        .data      (con_byte)
    );

    // CON_STAT: sticky overflow plus count saturated to its field.
    always_comb begin
        stat_word = '0;
        stat_word[STAT_OVF_BIT] = fifo_ovf;
        if (cnt32 > 32'd255)
            stat_word[STAT_CNT_LSB +: STAT_CNT_W] = 8'hFF;
        else
            stat_word[STAT_CNT_LSB +: STAT_CNT_W] = cnt32[7:0];
    end
`else
    logic unused_ok;

    assign con_valid = 1'b0;
    assign con_byte  = 8'h00;
    assign stat_word = '0;
    assign unused_ok = ^{mem_addr[1:0], con_ready};
`endif

    // Read mux; CON_DATA and anything undecoded read as zero.
    always_comb begin
        rd_word = '0;
        unique case (sel)
            SEL_RAM:      rd_word = ram[idx];
            SEL_CON_STAT: rd_word = stat_word;
            SEL_CYCLES:   rd_word = cycles;
            default:      rd_word = '0;
        endcase
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_ram)
            ram[idx] <= mem_write_data;
    end

    // Registered read data, fault flag and free-running cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data  <= '0;
            mem_fault <= 1'b0;
            cycles    <= '0;
        end else begin
            mem_data <= rd_word;
            cycles   <= cycles + 32'd1;
            if (sel == SEL_NONE)
                mem_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder.
// Stimulus queues expected reads/console bytes; a monitor pops and compares.
module tb_mem_responder;

    localparam logic [31:0] A_DATA = 32'hFFFF_0000;
    localparam logic [31:0] A_STAT = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
`ifdef MEM_CONSOLE_EN
    localparam bit CON_EN = 1'b1;
`else
    localparam bit CON_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_data;
    logic        mem_fault;
    logic        con_valid;
    logic        con_ready;
    logic [7:0]  con_byte;

    mem_responder #(
        .MEM_WORDS      (1024),
        .CON_DEPTH      (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_data       (mem_data),
        .mem_fault      (mem_fault),
        .con_valid      (con_valid),
        .con_ready      (con_ready),
        .con_byte       (con_byte)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rd_q [$];
    logic [7:0]  con_q [$];
    logic        rd_chk  = 1'b0;
    logic        rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: samples 3 time units after negedge, well clear of posedge.
    always begin
        @(negedge clk);
        #3;
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got %h want none", mem_data);
            end else begin
                check("rd_data", mem_data, rd_q.pop_front());
            end
        end
        rd_pend = rd_chk & ~reset;
        if (con_valid && con_ready && !reset) begin
            if (con_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL con_unexpected: got %h want none", con_byte);
            end else begin
                check("con_byte", {24'h0, con_byte}, {24'h0, con_q.pop_front()});
            end
        end
    end

    task automatic cyc(input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic chk,
                       input logic [31:0] exp);
        mem_addr       = a;
        mem_write_en   = we;
        mem_write_data = wd;
        rd_chk         = chk;
        if (chk)
            rd_q.push_back(exp);
        @(negedge clk);
        #1;
        mem_addr     = 32'h0;
        mem_write_en = 1'b0;
        rd_chk       = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(a, 1'b1, d, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        cyc(a, 1'b0, 32'h0, 1'b1, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic con_wr(input logic [7:0] b, input bit emit);
        if (CON_EN && emit)
            con_q.push_back(b);
        wr(A_DATA, {24'hABCDEF, b});
    endtask

    function automatic logic [31:0] stat(input logic [31:0] v);
        return CON_EN ? v : 32'h0;
    endfunction

    initial begin
        reset          = 1'b1;
        mem_addr       = 32'h0;
        mem_write_en   = 1'b0;
        mem_write_data = 32'h0;
        con_ready      = 1'b0;
        @(negedge clk);
        #1;
        idle(2);
        check("rst_mem_data", mem_data, 32'h0);
        check("rst_fault", {31'h0, mem_fault}, 32'h0);
        check("rst_con_valid", {31'h0, con_valid}, 32'h0);
        check("rst_con_byte", {24'h0, con_byte}, 32'h0);
        reset = 1'b0;

        // RAM round trip, read-first, top word
        wr(32'h0, 32'h0123_4567);
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF);
        rd(32'h13, 32'hDEAD_BEEF);
        rd(32'h0, 32'h0123_4567);
        wr(32'h20, 32'h1111_1111);
        cyc(32'h20, 1'b1, 32'h2222_2222, 1'b1, 32'h1111_1111);
        rd(32'h20, 32'h2222_2222);
        wr(32'hFFC, 32'hA5A5_5A5A);
        rd(32'hFFC, 32'hA5A5_5A5A);
        rd(32'h0, 32'h0123_4567);

        // Console drain
        con_wr(8'h41, 1'b1);
        con_wr(8'h42, 1'b1);
        rd(A_STAT, stat(32'h002));
        check("drain_valid", {31'h0, con_valid}, {31'h0, CON_EN});
        check("drain_head", {24'h0, con_byte}, CON_EN ? 32'h41 : 32'h0);
        con_ready = 1'b1;
        idle(2);
        check("drain_empty", {31'h0, con_valid}, 32'h0);
        con_ready = 1'b0;

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++)
            con_wr(8'h70 + 8'(i), 1'b1);
        con_ready = 1'b1;
        con_wr(8'h55, 1'b1);
        con_ready = 1'b0;
        rd(A_STAT, stat(32'h008));
        con_ready = 1'b1;
        idle(9);
        con_ready = 1'b0;
        check("full_empty", {31'h0, con_valid}, 32'h0);

        // Overflow: ninth byte dropped
        for (int i = 0; i < 9; i++)
            con_wr(8'h60 + 8'(i), i < 8);
        rd(A_STAT, stat(32'h108));
        con_ready = 1'b1;
        idle(10);
        con_ready = 1'b0;
        check("ovf_empty", {31'h0, con_valid}, 32'h0);

        // In-map MMIO writes never fault
        wr(A_STAT, 32'hFFFF_FFFF);
        wr(A_CYC, 32'h0);
        check("inmap_nofault", {31'h0, mem_fault}, 32'h0);

        // Out of map
        wr(32'h8000_0000, 32'hCAFE_F00D);
        check("oom_fault", {31'h0, mem_fault}, 32'h1);
        rd(32'h0, 32'h0123_4567);
        rd(32'h8000_0000, 32'h0);
        rd(32'hFFFF_000C, 32'h0);
        idle(3);
        check("oom_sticky", {31'h0, mem_fault}, 32'h1);

        // Reset mid-drain; write in the reset cycle is dropped
        con_wr(8'h31, 1'b1);
        con_wr(8'h32, 1'b1);
        con_wr(8'h33, 1'b1);
        con_ready = 1'b1;
        idle(1);
        con_q.delete();
        reset = 1'b1;
        cyc(32'h10, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0);
        reset = 1'b0;
        check("rst2_con_valid", {31'h0, con_valid}, 32'h0);
        check("rst2_con_byte", {24'h0, con_byte}, 32'h0);
        check("rst2_fault", {31'h0, mem_fault}, 32'h0);
        check("rst2_mem_data", mem_data, 32'h0);
        rd(A_CYC, 32'h0);
        cyc(A_CYC, 1'b1, 32'h0000_1234, 1'b1, 32'h1);
        rd(A_CYC, 32'h2);
        rd(32'h10, 32'hDEAD_BEEF);
        check("rst2_still_empty", {31'h0, con_valid}, 32'h0);
        con_ready = 1'b0;

        // First address past the RAM window faults
        rd(32'h1000, 32'h0);
        check("ram_edge_fault", {31'h0, mem_fault}, 32'h1);

        idle(2);
        check("rd_q_drained", rd_q.size(), 32'h0);
        check("con_q_drained", con_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
